// File: rtl/median_pkg.sv
// Shared types and comparison helpers for the 3x3 median stream core.
package median_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 4;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t lo;
    pix_t mid;
    pix_t hi;
  } col_sorted_t;

  localparam col_sorted_t COL_ZERO = '{lo: 8'h00, mid: 8'h00, hi: 8'h00};

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

endpackage

// File: rtl/median3x3_stream_core_sort3.sv
// Combinational 3-input sorting network producing lo/mid/hi of one pixel column.
module median_sort3
  import median_pkg::*;
(
  input  pix_t a,
  input  pix_t b,
  input  pix_t c,
  output pix_t lo,
  output pix_t mid,
  output pix_t hi
);

  pix_t ab_lo_s;
  pix_t ab_hi_s;
  pix_t bc_lo_s;

  assign ab_lo_s = min2(a, b);
  assign ab_hi_s = max2(a, b);
  assign bc_lo_s = min2(ab_hi_s, c);
  assign hi      = max2(ab_hi_s, c);
  assign lo      = min2(ab_lo_s, bc_lo_s);
  assign mid     = max2(ab_lo_s, bc_lo_s);

endmodule

// File: rtl/median3x3_stream_core.sv
// Streaming 3x3 median filter, 4 pixels per beat, 3 register stages with global stall.
// Optional MEDIAN3X3_BORDER_REPLICATE_EN: left border replicates column c0 instead of zeros.
module median3x3_stream_core
  import median_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PIX_W*PIX_PER_WORD-1:0]   word0,
  input  logic [PIX_W*PIX_PER_WORD-1:0]   word1,
  input  logic [PIX_W*PIX_PER_WORD-1:0]   word2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output pix_t                            pixel1,
  output pix_t                            pixel2,
  output pix_t                            pixel3,
  output pix_t                            pixel4
);

  if (PIX_PER_WORD != 4) begin : g_bad_pix_per_word
    $error("median3x3_stream_core supports exactly 4 pixels per word");
  end

  logic        stall_s;
  logic        accept_s;
  col_sorted_t new_col_s [0:3];
  col_sorted_t h_eff_s   [0:1];
  col_sorted_t hist_r    [0:1];
  col_sorted_t s1_col_r  [0:5];
  logic        s1_valid_r;
  pix_t        s2_a_r    [0:3];
  pix_t        s2_b_r    [0:3];
  pix_t        s2_c_r    [0:3];
  logic        s2_valid_r;
  pix_t        pixel_r   [0:3];
  logic        out_valid_r;

  assign stall_s   = out_valid_r && !out_ready;
  assign in_ready  = !stall_s;
  assign accept_s  = in_valid && !stall_s;
  assign out_valid = out_valid_r;
  assign pixel1    = pixel_r[0];
  assign pixel2    = pixel_r[1];
  assign pixel3    = pixel_r[2];
  assign pixel4    = pixel_r[3];

  for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_sort
    median_sort3 u_sort (
      .a   (word0[gi*PIX_W +: PIX_W]),
      .b   (word1[gi*PIX_W +: PIX_W]),
      .c   (word2[gi*PIX_W +: PIX_W]),
      .lo  (new_col_s[gi].lo),
      .mid (new_col_s[gi].mid),
      .hi  (new_col_s[gi].hi)
    );
  end

`ifdef MEDIAN3X3_BORDER_REPLICATE_EN
  logic first_r;

  // Marks the first accepted beat after reset as a line start.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r <= 1'b1;
    end else if (accept_s) begin
      first_r <= 1'b0;
    end
  end

  // Left-border columns: replicate c0 at a line start, else the carried history.
  always_comb begin
    h_eff_s[0] = hist_r[0];
    h_eff_s[1] = hist_r[1];
    if (frame_start || first_r) begin
      h_eff_s[0] = new_col_s[0];
      h_eff_s[1] = new_col_s[0];
    end else begin
      h_eff_s[0] = hist_r[0];
      h_eff_s[1] = hist_r[1];
    end
  end
`else
  // Left-border columns: zero columns at a line start, else the carried history.
  always_comb begin
    h_eff_s[0] = hist_r[0];
    h_eff_s[1] = hist_r[1];
    if (frame_start) begin
      h_eff_s[0] = COL_ZERO;
      h_eff_s[1] = COL_ZERO;
    end else begin
      h_eff_s[0] = hist_r[0];
      h_eff_s[1] = hist_r[1];
    end
  end
`endif

  // Stage 1: register sorted columns and roll the two-column history.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      hist_r[0]  <= COL_ZERO;
      hist_r[1]  <= COL_ZERO;
      for (int i = 0; i < 6; i++) s1_col_r[i] <= COL_ZERO;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_col_r[0] <= h_eff_s[0];
        s1_col_r[1] <= h_eff_s[1];
        for (int i = 0; i < 4; i++) s1_col_r[i+2] <= new_col_s[i];
        hist_r[0] <= new_col_s[2];
        hist_r[1] <= new_col_s[3];
      end
    end
  end

  // Stage 2: per window, max of lows, median of mids, min of highs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      for (int w = 0; w < 4; w++) begin
        s2_a_r[w] <= 8'h00;
        s2_b_r[w] <= 8'h00;
        s2_c_r[w] <= 8'h00;
      end
    end else if (!stall_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        for (int w = 0; w < 4; w++) begin
          s2_a_r[w] <= max3(s1_col_r[w].lo,  s1_col_r[w+1].lo,  s1_col_r[w+2].lo);
          s2_b_r[w] <= med3(s1_col_r[w].mid, s1_col_r[w+1].mid, s1_col_r[w+2].mid);
          s2_c_r[w] <= min3(s1_col_r[w].hi,  s1_col_r[w+1].hi,  s1_col_r[w+2].hi);
        end
      end
    end
  end

  // Stage 3: final median; pixels only change when a valid beat arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      for (int w = 0; w < 4; w++) pixel_r[w] <= 8'h00;
    end else if (!stall_s) begin
      out_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        for (int w = 0; w < 4; w++) pixel_r[w] <= med3(s2_a_r[w], s2_b_r[w], s2_c_r[w]);
      end
    end
  end

endmodule

// File: tb/tb_median3x3_stream_core.sv
// Scoreboard bench: reference model takes the true median of nine pixels per window.
module tb_median3x3_stream_core;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] word0;
  logic [31:0] word1;
  logic [31:0] word2;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  pixel1;
  logic [7:0]  pixel2;
  logic [7:0]  pixel3;
  logic [7:0]  pixel4;

  int          tests;
  int          failed;
  logic [31:0] sb_q[$];
  logic [7:0]  mh [0:1][0:2];
  bit          m_first;
  bit          mv [1:3];
  bit          last_acc;

  median3x3_stream_core dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_ready(in_ready), .word0(word0), .word1(word1), .word2(word2),
    .out_valid(out_valid), .out_ready(out_ready), .pixel1(pixel1),
    .pixel2(pixel2), .pixel3(pixel3), .pixel4(pixel4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] median9(input logic [7:0] v [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  task automatic model_accept();
    logic [7:0]  col [0:5][0:2];
    logic [31:0] w [3];
    logic [7:0]  win [9];
    logic [31:0] exp;
    bit          border;
    w = '{word0, word1, word2};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) col[c+2][r] = w[r][8*c +: 8];
`ifdef MEDIAN3X3_BORDER_REPLICATE_EN
    border = frame_start || m_first;
`else
    border = frame_start;
`endif
    for (int r = 0; r < 3; r++) begin
      if (border) begin
`ifdef MEDIAN3X3_BORDER_REPLICATE_EN
        col[0][r] = col[2][r];
        col[1][r] = col[2][r];
`else
        col[0][r] = 8'h00;
        col[1][r] = 8'h00;
`endif
      end else begin
        col[0][r] = mh[0][r];
        col[1][r] = mh[1][r];
      end
    end
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 3; k++)
        for (int r = 0; r < 3; r++) win[3*k+r] = col[p+k][r];
      exp[8*p +: 8] = median9(win);
    end
    sb_q.push_back(exp);
    for (int r = 0; r < 3; r++) begin
      mh[0][r] = col[4][r];
      mh[1][r] = col[5][r];
    end
    m_first = 1'b0;
  endtask

  // One clock: check handshake and deliveries at negedge, update the model, cross the edge.
  task automatic step();
    bit exp_stall;
    @(negedge clk);
    exp_stall = mv[3] && !out_ready;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mv[3]});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !exp_stall});
    if (out_valid === 1'b1 && out_ready) begin
      chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) chk("pixels", {pixel4, pixel3, pixel2, pixel1}, sb_q.pop_front());
    end
    last_acc = in_valid && !exp_stall;
    if (last_acc) model_accept();
    if (!exp_stall) begin
      mv[3] = mv[2];
      mv[2] = mv[1];
      mv[1] = last_acc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit fs, input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    in_valid = 1'b1; frame_start = fs; word0 = w0; word1 = w1; word2 = w2;
    step();
    in_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    for (int i = 1; i <= 3; i++) mv[i] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      mh[0][r] = 8'h00;
      mh[1][r] = 8'h00;
    end
    m_first = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_pixels", {pixel4, pixel3, pixel2, pixel1}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         sent;
    int         cyc;
    int         n;
    logic [3:0] pat;
    clk = 1'b0; rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    word0 = 32'd0; word1 = 32'd0; word2 = 32'd0;
    tests = 0; failed = 0; m_first = 1'b1;
    do_reset();

    // Flat 5s: zero left border on the first beat, then all 5s.
    send(1'b1, 32'h05050505, 32'h05050505, 32'h05050505);
    send(1'b0, 32'h05050505, 32'h05050505, 32'h05050505);
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
    idle(4);

    // Salt spike in the middle row is rejected.
    send(1'b1, 32'h10101010, 32'h10101010, 32'h10101010);
    send(1'b0, 32'h10101010, 32'h10101010, 32'h10101010);
    send(1'b0, 32'h10101010, 32'h10FF1010, 32'h10101010);
    idle(4);

    // Ramp across a beat boundary.
    send(1'b1, 32'h04030201, 32'h04030201, 32'h04030201);
    send(1'b0, 32'h08070605, 32'h08070605, 32'h08070605);
    idle(4);

    // Downstream not ready while idle must not stall.
    out_ready = 1'b0;
    idle(2);
    out_ready = 1'b1;

    // Back-to-back beats under a 1,0,0,1 out_ready pattern.
    pat = 4'b1001; sent = 0; cyc = 0;
    word0 = $urandom; word1 = $urandom; word2 = $urandom;
    while (sent < 8 && cyc < 64) begin
      out_ready = pat[cyc % 4];
      in_valid = 1'b1;
      frame_start = (sent == 0);
      step();
      if (last_acc) begin
        sent++;
        word0 = $urandom; word1 = $urandom; word2 = $urandom;
      end
      cyc++;
    end
    in_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    chk("beats_accepted", sent, 32'd8);
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_empty", sb_q.size(), 32'd0);

    // Reset with two beats in flight: nothing stale emerges, history restarts.
    send(1'b1, $urandom, $urandom, $urandom);
    send(1'b0, $urandom, $urandom, $urandom);
    do_reset();
    idle(3);
    send(1'b0, 32'h05050505, 32'h05050505, 32'h05050505);
    idle(4);
    chk("final_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
